// File: rtl/sequence_detector_prog.sv
// Runtime-programmable Moore serial sequence detector with overlap mode,
// qualified sampling and a saturating match counter.
module sequence_detector_prog #(
    parameter int unsigned          MAX_LEN       = 8,
    parameter logic [MAX_LEN-1:0]   RESET_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int unsigned          RESET_LEN     = 4,
    parameter bit                   OVERLAP       = 1'b1,
    parameter int unsigned          COUNT_W       = 8,
    localparam int unsigned         LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sequence_in,
    input  logic               pattern_load,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               count_clear,
    output logic               detector_out,
    output logic [COUNT_W-1:0] match_count,
    output logic               fill_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DETECT = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [MAX_LEN-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 det_q, det_d;
    logic                 fill_done_q, fill_done_d;

    logic [MAX_LEN-1:0]   hist_shift;
    logic [MAX_LEN-1:0]   len_mask;
    logic [LEN_W-1:0]     fill_inc;
    logic [LEN_W-1:0]     load_len;
    logic                 accept;
    logic                 match;

    // Next-state, history, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        count_d     = count_q;
        det_d       = det_q;
        fill_done_d = fill_done_q;

        hist_shift = {hist_q[MAX_LEN-2:0], sequence_in};
        fill_inc   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        match    = (fill_inc >= len_q) && (((hist_shift ^ pattern_q) & len_mask) == '0);
        accept   = enable & ~pattern_load;
        load_len = ((len_in == '0) || (len_in > MAX_LEN_L)) ? MAX_LEN_L : len_in;

        // A load restarts the search with the new pattern; the sampled bit is dropped.
        if (pattern_load) begin
            pattern_d = pattern_in;
            len_d     = load_len;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = IDLE;
        end else if (enable) begin
            if (match) begin
                state_d = DETECT;
                if (OVERLAP) begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                end else begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end else begin
                state_d = (fill_inc >= len_q) ? SEARCH : IDLE;
                hist_d  = hist_shift;
                fill_d  = fill_inc;
            end
        end

        // Clear wins over a simultaneous match; counter never wraps.
        if (count_clear) begin
            count_d = '0;
        end else if (accept && match && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_W'(1);
        end

        det_d       = (state_d == DETECT);
        fill_done_d = (fill_d >= len_d);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            pattern_q   <= RESET_PATTERN;
            len_q       <= LEN_W'(RESET_LEN);
            hist_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            det_q       <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            det_q       <= det_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign detector_out = det_q;
    assign match_count  = count_q;
    assign fill_done    = fill_done_q;

endmodule

// File: tb/tb_sequence_detector_prog.sv
// Directed bench: three detector variants (overlap, non-overlap, 2-bit
// counter) share one input stream; each step checks hand-computed results.
module tb_sequence_detector_prog;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       sequence_in;
    logic       pattern_load;
    logic [7:0] pattern_in;
    logic [3:0] len_in;
    logic       count_clear;

    logic       det_a, det_b, det_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       fd_a, fd_b, fd_c;

    int total = 0;
    int bad   = 0;

    sequence_detector_prog u_a (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .len_in(len_in),
        .count_clear(count_clear), .detector_out(det_a), .match_count(cnt_a),
        .fill_done(fd_a)
    );

    sequence_detector_prog #(.OVERLAP(1'b0)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .len_in(len_in),
        .count_clear(count_clear), .detector_out(det_b), .match_count(cnt_b),
        .fill_done(fd_b)
    );

    sequence_detector_prog #(.COUNT_W(2)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .len_in(len_in),
        .count_clear(count_clear), .detector_out(det_c), .match_count(cnt_c),
        .fill_done(fd_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given qualifier/bit; one-shot strobes drop afterwards.
    task automatic step(input logic en, input logic d);
        enable      = en;
        sequence_in = d;
        @(posedge clock);
        #1;
        pattern_load = 1'b0;
        count_clear  = 1'b0;
    endtask

    task automatic feed(input logic d, input logic exp_a);
        step(1'b1, d);
        chk("det_a", 32'(det_a), 32'(exp_a));
    endtask

    task automatic feed2(input logic d, input logic exp_a, input logic exp_b);
        step(1'b1, d);
        chk("det_a", 32'(det_a), 32'(exp_a));
        chk("det_b", 32'(det_b), 32'(exp_b));
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        sequence_in  = 1'b1;
        pattern_load = 1'b0;
        pattern_in   = 8'h00;
        len_in       = 4'd0;
        count_clear  = 1'b0;

        // Reset held for three cycles.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_det_a", 32'(det_a), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_fd_a",  32'(fd_a),  32'd0);
        chk("rst_cnt_c", 32'(cnt_c), 32'd0);
        reset = 1'b1;

        // 0,0,1,0,1,1 -> single match on the last bit.
        feed(1'b0, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        chk("fill3_fd_a", 32'(fd_a), 32'd0);
        feed(1'b0, 1'b0);
        chk("fill4_fd_a", 32'(fd_a), 32'd1);
        feed(1'b1, 1'b0);
        feed(1'b1, 1'b1);
        chk("first_cnt_a", 32'(cnt_a), 32'd1);
        chk("first_det_b", 32'(det_b), 32'd1);
        chk("first_cnt_b", 32'(cnt_b), 32'd1);
        chk("first_fd_b",  32'(fd_b),  32'd0);

        // Clear counters with enable low; DETECT holds.
        count_clear = 1'b1;
        step(1'b0, 1'b0);
        chk("hold_det_a", 32'(det_a), 32'd1);
        chk("clr_cnt_a",  32'(cnt_a), 32'd0);
        chk("clr_cnt_b",  32'(cnt_b), 32'd0);

        // 1,0,1,1,0,1,1: overlap sees two matches, non-overlap one.
        feed2(1'b1, 1'b0, 1'b0);
        feed2(1'b0, 1'b0, 1'b0);
        feed2(1'b1, 1'b0, 1'b0);
        feed2(1'b1, 1'b1, 1'b1);
        chk("nov_fd_b", 32'(fd_b), 32'd0);
        feed2(1'b0, 1'b0, 1'b0);
        feed2(1'b1, 1'b0, 1'b0);
        feed2(1'b1, 1'b1, 1'b0);
        chk("ov_cnt_a",  32'(cnt_a), 32'd2);
        chk("nov_cnt_b", 32'(cnt_b), 32'd1);
        chk("ov_cnt_c",  32'(cnt_c), 32'd2);

        // 1,0,1, three idle cycles with junk data, then 1 completes the pattern.
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("gap_det_a", 32'(det_a), 32'd0);
        step(1'b0, 1'b0);
        chk("gap_det_a", 32'(det_a), 32'd0);
        step(1'b0, 1'b1);
        chk("gap_det_a", 32'(det_a), 32'd0);
        feed(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("gap_hold_a", 32'(det_a), 32'd1);
        step(1'b0, 1'b1);
        chk("gap_hold_a", 32'(det_a), 32'd1);
        chk("gap_cnt_a",  32'(cnt_a), 32'd3);
        chk("gap_cnt_c",  32'(cnt_c), 32'd3);

        // Load 110/len 3 where the old 1011 would have completed.
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        pattern_in   = 8'b0000_0110;
        len_in       = 4'd3;
        pattern_load = 1'b1;
        step(1'b1, 1'b1);
        chk("load_det_a", 32'(det_a), 32'd0);
        chk("load_fd_a",  32'(fd_a),  32'd0);
        chk("load_cnt_a", 32'(cnt_a), 32'd3);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        feed(1'b1, 1'b0);
        chk("load_fill_a", 32'(fd_a), 32'd1);
        feed(1'b0, 1'b1);
        chk("new_cnt_a", 32'(cnt_a), 32'd4);
        chk("sat4_cnt_c", 32'(cnt_c), 32'd3);

        // Fifth match keeps the 2-bit counter at 3; clear beats a match.
        feed(1'b1, 1'b0);
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b1);
        chk("m5_cnt_a",   32'(cnt_a), 32'd5);
        chk("sat5_cnt_c", 32'(cnt_c), 32'd3);
        feed(1'b1, 1'b0);
        feed(1'b1, 1'b0);
        count_clear = 1'b1;
        feed(1'b0, 1'b1);
        chk("clrwin_cnt_a", 32'(cnt_a), 32'd0);
        chk("clrwin_cnt_c", 32'(cnt_c), 32'd0);

        // Reset restores 1011/len 4; a pattern straddling reset is not seen.
        reset = 1'b0;
        step(1'b1, 1'b1);
        chk("rst2_det_a", 32'(det_a), 32'd0);
        chk("rst2_fd_a",  32'(fd_a),  32'd0);
        reset = 1'b1;
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b1);
        reset = 1'b1;
        feed(1'b1, 1'b0);
        chk("straddle_cnt_a", 32'(cnt_a), 32'd0);
        chk("straddle_fd_a",  32'(fd_a),  32'd0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        feed(1'b1, 1'b1);
        chk("post_rst_cnt_a", 32'(cnt_a), 32'd1);

        // len=1: every accepted 1 matches.
        pattern_in   = 8'h01;
        len_in       = 4'd1;
        pattern_load = 1'b1;
        step(1'b1, 1'b0);
        chk("len1_load_det_a", 32'(det_a), 32'd0);
        feed(1'b1, 1'b1);
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b0);
        chk("len1_cnt_a", 32'(cnt_a), 32'd3);

        // len_in=0 clamps to 8: full 0xA5 must be seen before a match.
        pattern_in   = 8'hA5;
        len_in       = 4'd0;
        pattern_load = 1'b1;
        step(1'b1, 1'b0);
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        chk("clamp_fd7_a", 32'(fd_a), 32'd0);
        feed(1'b1, 1'b1);
        chk("clamp_fd8_a", 32'(fd_a), 32'd1);
        chk("clamp_cnt_a", 32'(cnt_a), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
